fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
//  - Holds the PC and issues requests to instruction memory over a req/ready handshake.
//  - Captures PC+4 and the instruction into IF/ID.
//  - Takes pc_decode / redirect from the decode-stage address unit (jump > branch > pc_next).
//  - Honours hazard-unit stalls through a one-entry skid buffer. No branch delay slot.

---
 rtl/core_pkg.sv | 20 ++
 rtl/fetch_skid_buffer.sv | 52 +++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core front end.
// Holds the fetch FSM encoding and instruction-word constants.
package core_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register holding a fetched {pc_next, instr} pair while IF/ID is stalled.
// clear has priority over load.
module fetch_skid_buffer
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc_next,
    input  logic [31:0] load_instr,
    output logic        full,
    output logic [31:0] pc_next,
    output logic [31:0] instr
);

    logic        full_q, full_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        full_d    = full_q;
        pc_next_d = pc_next_q;
        instr_d   = instr_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d    = 1'b1;
            pc_next_d = load_pc_next;
            instr_d   = load_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            pc_next_q <= 32'h0000_0000;
            instr_q   <= NOP_INSTR;
        end else begin
            full_q    <= full_d;
            pc_next_q <= pc_next_d;
            instr_q   <= instr_d;
        end
    end

    assign full    = full_q;
    assign pc_next = pc_next_q;
    assign instr   = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Handshake: a transfer happens on any cycle with imem_req && imem_ready; imem_addr is held while waiting.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  pc_decode,
    input  logic         redirect,
    input  logic         stall,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic         if_id_valid,
    output logic [31:0]  if_id_pc_next,
    output logic [31:0]  if_id_instruction,
    output logic [31:0]  pc_current,
    output fetch_state_t dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  if_id_pc_next_q, if_id_pc_next_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;

    logic         skid_load, skid_clear, skid_full;
    logic [31:0]  skid_pc_next, skid_instr;
    logic [31:0]  seq_addr;

    assign seq_addr = next_word_addr(req_addr_q);

    fetch_skid_buffer #(
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (skid_load),
        .clear        (skid_clear),
        .load_pc_next (seq_addr),
        .load_instr   (imem_rdata),
        .full         (skid_full),
        .pc_next      (skid_pc_next),
        .instr        (skid_instr)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        if_id_valid_d   = if_id_valid_q;
        if_id_pc_next_d = if_id_pc_next_q;
        if_id_instr_d   = if_id_instr_q;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;

        case (state_q)
            S_BOOT: begin
                if (redirect) begin
                    pc_d       = pc_decode;
                    req_addr_d = pc_decode;
                end
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (redirect) begin
                    pc_d          = pc_decode;
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    if (imem_ready) begin
                        req_addr_d = pc_decode;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_ready) begin
                    pc_d = seq_addr;
                    if (!stall) begin
                        if_id_valid_d   = 1'b1;
                        if_id_pc_next_d = seq_addr;
                        if_id_instr_d   = imem_rdata;
                        req_addr_d      = seq_addr;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end

            // A stale request is still outstanding; its data must be thrown away.
            S_DROP: begin
                if (redirect) begin
                    pc_d = pc_decode;
                end
                if (imem_ready) begin
                    req_addr_d = redirect ? pc_decode : pc_q;
                    state_d    = S_FETCH;
                end
                if (!stall || redirect) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    skid_clear    = 1'b1;
                    pc_d          = pc_decode;
                    req_addr_d    = pc_decode;
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    state_d       = S_FETCH;
                end else if (!stall) begin
                    skid_clear      = 1'b1;
                    if_id_valid_d   = skid_full;
                    if_id_pc_next_d = skid_pc_next;
                    if_id_instr_d   = skid_instr;
                    req_addr_d      = pc_q;
                    state_d         = S_FETCH;
                end
            end

            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_PC;
            req_addr_q      <= RESET_PC;
            if_id_valid_q   <= 1'b0;
            if_id_pc_next_q <= 32'h0000_0000;
            if_id_instr_q   <= NOP_INSTR;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_addr_q      <= req_addr_d;
            if_id_valid_q   <= if_id_valid_d;
            if_id_pc_next_q <= if_id_pc_next_d;
            if_id_instr_q   <= if_id_instr_d;
        end
    end

    assign imem_req          = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem_addr         = req_addr_q;
    assign if_id_valid       = if_id_valid_q;
    assign if_id_pc_next     = if_id_pc_next_q;
    assign if_id_instruction = if_id_instr_q;
    assign pc_current        = pc_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with an address-tagged instruction memory.
module tb_fetch_stage;
    import core_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [31:0]  pc_decode;
    logic         redirect;
    logic         stall;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic         if_id_valid;
    logic [31:0]  if_id_pc_next;
    logic [31:0]  if_id_instruction;
    logic [31:0]  pc_current;
    fetch_state_t dbg_state;

    int total;
    int bad;

    fetch_stage dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_decode         (pc_decode),
        .redirect          (redirect),
        .stall             (stall),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .if_id_valid       (if_id_valid),
        .if_id_pc_next     (if_id_pc_next),
        .if_id_instruction (if_id_instruction),
        .pc_current        (pc_current),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = tag(imem_addr);

    typedef struct {
        logic         redirect;
        logic         stall;
        logic         ready;
        logic [31:0]  pc_decode;
        logic         e_req;
        logic [31:0]  e_addr;
        logic         e_valid;
        logic [31:0]  e_pcn;
        logic [31:0]  e_instr;
        logic [31:0]  e_pc;
        fetch_state_t e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rd, input logic st, input logic rdy, input logic [31:0] pcd,
                       input logic ereq, input logic [31:0] eaddr, input logic ev,
                       input logic [31:0] epcn, input logic [31:0] eins, input logic [31:0] epc,
                       input fetch_state_t es);
        vec_t v;
        v.redirect = rd; v.stall = st; v.ready = rdy; v.pc_decode = pcd;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_pcn = epcn;
        v.e_instr = eins; v.e_pc = epc; v.e_state = es;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; pc_decode = '0; redirect = 1'b0; stall = 1'b0; imem_ready = 1'b1;

        // redirect, stall, ready, pc_decode | req, addr (pre-edge) | valid, pc_next, instr, pc, state (post-edge)
        add(0,0,1,32'h0,    0,32'h0,       0,32'h0,  32'h0,       32'h0,       S_FETCH);
        add(0,0,1,32'h0,    1,32'h0,       1,32'h4,  tag(32'h0),  32'h4,       S_FETCH);
        add(0,0,1,32'h0,    1,32'h4,       1,32'h8,  tag(32'h4),  32'h8,       S_FETCH);
        add(0,1,1,32'h0,    1,32'h8,       1,32'h8,  tag(32'h4),  32'hC,       S_HOLD);
        add(0,1,1,32'h0,    0,32'h8,       1,32'h8,  tag(32'h4),  32'hC,       S_HOLD);
        add(0,1,1,32'h0,    0,32'h8,       1,32'h8,  tag(32'h4),  32'hC,       S_HOLD);
        add(0,0,1,32'h0,    0,32'h8,       1,32'hC,  tag(32'h8),  32'hC,       S_FETCH);
        add(0,0,1,32'h0,    1,32'hC,       1,32'h10, tag(32'hC),  32'h10,      S_FETCH);
        add(1,0,1,32'h100,  1,32'h10,      0,32'h10, 32'h0,       32'h100,     S_FETCH);
        add(0,0,1,32'h0,    1,32'h100,     1,32'h104,tag(32'h100),32'h104,     S_FETCH);
        add(1,0,1,32'h20,   1,32'h104,     0,32'h104,32'h0,       32'h20,      S_FETCH);
        add(1,0,0,32'h200,  1,32'h20,      0,32'h104,32'h0,       32'h200,     S_DROP);
        add(0,0,0,32'h0,    1,32'h20,      0,32'h104,32'h0,       32'h200,     S_DROP);
        add(0,0,1,32'h0,    1,32'h20,      0,32'h104,32'h0,       32'h200,     S_FETCH);
        add(0,0,1,32'h0,    1,32'h200,     1,32'h204,tag(32'h200),32'h204,     S_FETCH);
        add(0,1,1,32'h0,    1,32'h204,     1,32'h204,tag(32'h200),32'h208,     S_HOLD);
        add(1,1,1,32'h300,  0,32'h204,     0,32'h204,32'h0,       32'h300,     S_FETCH);
        add(0,0,1,32'h0,    1,32'h300,     1,32'h304,tag(32'h300),32'h304,     S_FETCH);
        add(1,0,1,32'hFFFF_FFFC, 1,32'h304,0,32'h304,32'h0,       32'hFFFF_FFFC,S_FETCH);
        add(0,0,1,32'h0,    1,32'hFFFF_FFFC,1,32'h0, tag(32'hFFFF_FFFC),32'h0, S_FETCH);
        add(0,0,1,32'h0,    1,32'h0,       1,32'h4,  tag(32'h0),  32'h4,       S_FETCH);
        add(0,0,0,32'h0,    1,32'h4,       0,32'h4,  32'h0,       32'h4,       S_FETCH);
        add(0,0,1,32'h0,    1,32'h4,       1,32'h8,  tag(32'h4),  32'h8,       S_FETCH);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_pcn",   if_id_pc_next,        32'h0);
        chk("rst_instr", if_id_instruction,    32'h0);
        chk("rst_pc",    pc_current,           32'h0);
        chk("rst_state", {30'b0, dbg_state},   {30'b0, S_BOOT});
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            redirect   = vecs[i].redirect;
            stall      = vecs[i].stall;
            imem_ready = vecs[i].ready;
            pc_decode  = vecs[i].pc_decode;
            #1;
            chk($sformatf("v%0d_req", i),  {31'b0, imem_req}, {31'b0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), imem_addr,         vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_pcn", i),   if_id_pc_next,        vecs[i].e_pcn);
            chk($sformatf("v%0d_instr", i), if_id_instruction,    vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i),    pc_current,           vecs[i].e_pc);
            chk($sformatf("v%0d_state", i), {30'b0, dbg_state},   {30'b0, vecs[i].e_state});
            @(negedge clk);
        end

        // Reset asserted asynchronously while a dropped request is outstanding.
        redirect = 1'b1; pc_decode = 32'h400; imem_ready = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_state", {30'b0, dbg_state}, {30'b0, S_DROP});
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'b0, imem_req},    32'h0);
        chk("arst_addr",  imem_addr,            32'h0);
        chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("arst_pcn",   if_id_pc_next,        32'h0);
        chk("arst_instr", if_id_instruction,    32'h0);
        chk("arst_pc",    pc_current,           32'h0);
        chk("arst_state", {30'b0, dbg_state},   {30'b0, S_BOOT});

        // After re-release the first request goes to RESET_PC, not the abandoned target.
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reboot_req",  {31'b0, imem_req}, 32'h1);
        chk("reboot_addr", imem_addr,         32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
